// File: rtl/cv32e40px_apu_core_pkg.sv
// ============================================================================
// Module   : cv32e40px_apu_core_pkg
// Brief    : APU interface widths and the dispatcher order-FIFO entry type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cv32e40px_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    // Wide enough for up to four units; out-of-range targets use the err marker.
    localparam int APU_ORD_UNIT_W   = 2;

    typedef struct packed {
        logic                      err;
        logic [APU_ORD_UNIT_W-1:0] unit;
    } apu_ord_entry_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40px_apu_res_fifo.sv
// ============================================================================
// Module   : cv32e40px_apu_res_fifo
// Brief    : Small show-ahead FIFO used for issue order and per-unit results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cv32e40px_apu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cv32e40px_apu_dispatcher.sv
// ============================================================================
// Module   : cv32e40px_apu_dispatcher
// Brief    : Routes core APU requests to N units and returns results in order.
//            APU_DISPATCH_PERF_EN adds stall/return performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cv32e40px_apu_dispatcher
    import cv32e40px_apu_core_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int DEPTH     = 4,
    parameter int UNIT_W    = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  apu_req_i,
    output logic                                  apu_gnt_o,
    input  logic [UNIT_W-1:0]                     apu_unit_i,
    input  logic [APU_NARGS_CPU*32-1:0]           apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]                apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]           apu_flags_i,
    output logic                                  apu_rvalid_o,
    output logic [31:0]                           apu_rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]           apu_rflags_o,
    output logic [NUM_UNITS-1:0]                  unit_req_o,
    input  logic [NUM_UNITS-1:0]                  unit_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]           unit_operands_o,
    output logic [APU_WOP_CPU-1:0]                unit_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]           unit_flags_o,
    input  logic [NUM_UNITS-1:0]                  unit_rvalid_i,
    input  logic [NUM_UNITS*32-1:0]               unit_rdata_i,
    input  logic [NUM_UNITS*APU_NUSFLAGS_CPU-1:0] unit_rflags_i,
    output logic [$clog2(DEPTH):0]                outstanding_o,
`ifdef APU_DISPATCH_PERF_EN
    output logic [31:0]                           perf_stall_cnt_o,
    output logic [31:0]                           perf_ret_cnt_o,
`endif
    output logic                                  err_o
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_res_w = 32 + APU_NUSFLAGS_CPU;
    localparam int c_ord_w = $bits(apu_ord_entry_t);

    logic                 w_full;
    logic                 w_in_range;
    logic                 w_gnt_sel;
    logic                 w_accept;
    logic                 w_ord_pop;
    logic                 w_ord_empty;
    logic                 w_ord_full;
    logic [c_cnt_w-1:0]   w_ord_count;
    apu_ord_entry_t       w_push_entry;
    apu_ord_entry_t       w_head;
    logic                 w_rvalid;
    logic [31:0]          w_rdata;
    logic [APU_NUSFLAGS_CPU-1:0] w_rflags;
    logic [NUM_UNITS-1:0] w_buf_push;
    logic [NUM_UNITS-1:0] w_buf_pop;
    logic [NUM_UNITS-1:0] w_buf_empty;
    logic [NUM_UNITS-1:0] w_buf_full;
    logic [NUM_UNITS-1:0] w_drop;
    logic [c_res_w-1:0]   w_buf_rdata [NUM_UNITS];
    logic                 r_err;

    assign unit_operands_o = apu_operands_i;
    assign unit_op_o       = apu_op_i;
    assign unit_flags_o    = apu_flags_i;

    assign w_in_range = (32'(apu_unit_i) < NUM_UNITS);
    assign w_full     = w_ord_full;

    // Out-of-range targets have no unit to wait on and are granted directly.
    always_comb begin
        w_gnt_sel = 1'b1;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (apu_unit_i == UNIT_W'(u)) begin
                w_gnt_sel = unit_gnt_i[u];
            end
        end
    end

    assign apu_gnt_o         = w_gnt_sel & ~w_full;
    assign w_accept          = apu_req_i & apu_gnt_o;
    assign w_push_entry.err  = ~w_in_range;
    assign w_push_entry.unit = APU_ORD_UNIT_W'(apu_unit_i);

    cv32e40px_apu_res_fifo #(
        .WIDTH (c_ord_w),
        .DEPTH (DEPTH)
    ) u_ord_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_accept),
        .i_wdata (w_push_entry),
        .i_pop   (w_ord_pop),
        .o_rdata (w_head),
        .o_full  (w_ord_full),
        .o_empty (w_ord_empty),
        .o_count (w_ord_count)
    );

    assign outstanding_o = w_ord_count;

    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            logic [c_cnt_w-1:0] r_issued;
            logic [c_cnt_w-1:0] w_buf_count;
            logic               w_issue;

            assign unit_req_o[u] = apu_req_i & (apu_unit_i == UNIT_W'(u)) & ~w_full;
            assign w_issue       = w_accept & w_in_range & (apu_unit_i == UNIT_W'(u));

            // A result is only legal while some issued op still lacks its result.
            assign w_buf_push[u] = unit_rvalid_i[u] & (r_issued > w_buf_count) & ~w_buf_full[u];
            assign w_drop[u]     = unit_rvalid_i[u] & ~w_buf_push[u];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_issued <= '0;
                end else if (w_issue & ~w_buf_pop[u]) begin
                    r_issued <= r_issued + 1'b1;
                end else if (~w_issue & w_buf_pop[u]) begin
                    r_issued <= r_issued - 1'b1;
                end
            end

            cv32e40px_apu_res_fifo #(
                .WIDTH (c_res_w),
                .DEPTH (DEPTH)
            ) u_res_fifo (
                .clk     (clk_i),
                .rst     (rst_i),
                .i_push  (w_buf_push[u]),
                .i_wdata ({unit_rdata_i[u*32 +: 32],
                           unit_rflags_i[u*APU_NUSFLAGS_CPU +: APU_NUSFLAGS_CPU]}),
                .i_pop   (w_buf_pop[u]),
                .o_rdata (w_buf_rdata[u]),
                .o_full  (w_buf_full[u]),
                .o_empty (w_buf_empty[u]),
                .o_count (w_buf_count)
            );
        end
    endgenerate

    // Retire the order-FIFO head once its unit's result is buffered.
    always_comb begin
        w_ord_pop = 1'b0;
        w_rvalid  = 1'b0;
        w_rdata   = '0;
        w_rflags  = '0;
        w_buf_pop = '0;
        if (!w_ord_empty) begin
            if (w_head.err) begin
                w_ord_pop = 1'b1;
                w_rvalid  = 1'b1;
            end else begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if ((w_head.unit == APU_ORD_UNIT_W'(u)) && !w_buf_empty[u]) begin
                        w_ord_pop    = 1'b1;
                        w_rvalid     = 1'b1;
                        w_buf_pop[u] = 1'b1;
                        {w_rdata, w_rflags} = w_buf_rdata[u];
                    end
                end
            end
        end
    end

    assign apu_rvalid_o = w_rvalid;
    assign apu_rdata_o  = w_rdata;
    assign apu_rflags_o = w_rflags;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((w_accept & ~w_in_range) | (|w_drop)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

`ifdef APU_DISPATCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_ret_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (apu_req_i & ~apu_gnt_o & ~(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_rvalid & ~(&r_ret_cnt)) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_ret_cnt_o   = r_ret_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cv32e40px_apu_dispatcher.sv
// ============================================================================
// Module   : tb_cv32e40px_apu_dispatcher
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            compared against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40px_apu_dispatcher;

    localparam int NUM_UNITS = 2;
    localparam int DEPTH     = 4;
    localparam int UNIT_W    = 2;
    localparam int NUS       = 5;

    typedef struct packed {
        logic [1:0]  unit;
        logic [31:0] d;
        logic [4:0]  f;
    } res_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  unit;
    logic [95:0] ops;
    logic [5:0]  op;
    logic [14:0] fl;
    logic [1:0]  gnt;
    logic [1:0]  urv;
    logic [63:0] urdata;
    logic [9:0]  urflags;

    logic        apu_gnt_o;
    logic        apu_rvalid_o;
    logic [31:0] apu_rdata_o;
    logic [4:0]  apu_rflags_o;
    logic [1:0]  unit_req_o;
    logic [95:0] unit_operands_o;
    logic [5:0]  unit_op_o;
    logic [14:0] unit_flags_o;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ord_q[$];
    res_t res_q[$];
    bit   m_err;
    bit   e_gnt;
    bit   e_pop;
    int   e_idx;

    cv32e40px_apu_dispatcher #(
        .NUM_UNITS (NUM_UNITS),
        .DEPTH     (DEPTH),
        .UNIT_W    (UNIT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .apu_req_i       (req),
        .apu_gnt_o       (apu_gnt_o),
        .apu_unit_i      (unit),
        .apu_operands_i  (ops),
        .apu_op_i        (op),
        .apu_flags_i     (fl),
        .apu_rvalid_o    (apu_rvalid_o),
        .apu_rdata_o     (apu_rdata_o),
        .apu_rflags_o    (apu_rflags_o),
        .unit_req_o      (unit_req_o),
        .unit_gnt_i      (gnt),
        .unit_operands_o (unit_operands_o),
        .unit_op_o       (unit_op_o),
        .unit_flags_o    (unit_flags_o),
        .unit_rvalid_i   (urv),
        .unit_rdata_i    (urdata),
        .unit_rflags_i   (urflags),
        .outstanding_o   (outstanding_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ops issued to unit u whose result has not yet come back.
    function automatic int pending(input int u);
        int n = 0;
        foreach (ord_q[i]) if (ord_q[i] == u) n++;
        foreach (res_q[i]) if (int'(res_q[i].unit) == u) n--;
        return n;
    endfunction

    task automatic idle();
        req     = 1'b0;
        unit    = 2'd0;
        gnt     = 2'b00;
        urv     = 2'b00;
        urdata  = '0;
        urflags = '0;
        rst     = 1'b0;
        ops     = {$urandom, $urandom, $urandom};
        op      = 6'($urandom);
        fl      = 15'($urandom);
    endtask

    task automatic issue(input logic [1:0] u, input logic [1:0] g);
        idle();
        req  = 1'b1;
        unit = u;
        gnt  = g;
    endtask

    task automatic set_res(input int u, input logic [31:0] d, input logic [4:0] f);
        urv[u]               = 1'b1;
        urdata[u*32 +: 32]   = d;
        urflags[u*NUS +: NUS] = f;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_cycle();
        logic [1:0]  e_req;
        logic [31:0] e_d;
        logic [4:0]  e_f;
        bit          full;
        @(negedge clk);
        full = (ord_q.size() == DEPTH);
        for (int u = 0; u < NUM_UNITS; u++) e_req[u] = req && (int'(unit) == u) && !full;
        e_gnt = (int'(unit) < NUM_UNITS) ? (!full && gnt[unit]) : !full;
        e_pop = 1'b0;
        e_idx = -1;
        e_d   = '0;
        e_f   = '0;
        if (ord_q.size() > 0) begin
            if (ord_q[0] < 0) begin
                e_pop = 1'b1;
            end else begin
                for (int i = 0; i < res_q.size(); i++) begin
                    if (!e_pop && int'(res_q[i].unit) == ord_q[0]) begin
                        e_pop = 1'b1;
                        e_idx = i;
                        e_d   = res_q[i].d;
                        e_f   = res_q[i].f;
                    end
                end
            end
        end
        check_val("gnt", apu_gnt_o, e_gnt);
        check_val("unit_req", unit_req_o, e_req);
        check_val("rvalid", apu_rvalid_o, e_pop);
        check_val("rdata", apu_rdata_o, e_d);
        check_val("rflags", apu_rflags_o, e_f);
        check_val("outstanding", outstanding_o, ord_q.size());
        check_val("err", err_o, m_err);
        check_val("payload", {unit_op_o, unit_flags_o, unit_operands_o[31:0]}, {op, fl, ops[31:0]});
    endtask

    task automatic advance();
        int pend[NUM_UNITS];
        @(posedge clk);
        if (rst) begin
            ord_q.delete();
            res_q.delete();
            m_err = 1'b0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) pend[u] = pending(u);
            if (e_pop) begin
                if (e_idx >= 0) res_q.delete(e_idx);
                void'(ord_q.pop_front());
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (urv[u]) begin
                    if (pend[u] > 0) res_q.push_back({2'(u), urdata[u*32 +: 32], urflags[u*NUS +: NUS]});
                    else m_err = 1'b1;
                end
            end
            if (req && e_gnt) begin
                if (int'(unit) < NUM_UNITS) ord_q.push_back(int'(unit));
                else begin
                    ord_q.push_back(-1);
                    m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst   = 1'b1;
        m_err = 1'b0;
        e_pop = 1'b0;
        e_gnt = 1'b0;
        advance();
        check_cycle();
        check_val("reset_outstanding", outstanding_o, 3'd0);
        check_val("reset_rvalid", apu_rvalid_o, 1'b0);
        advance();
        idle();

        // Single op to unit0, result three cycles after acceptance.
        issue(2'd0, 2'b01);
        step();
        idle(); step();
        idle(); step();
        set_res(0, 32'h3F800000, 5'h00); step();
        idle();
        check_cycle();
        check_val("s1_rvalid", apu_rvalid_o, 1'b1);
        check_val("s1_rdata", apu_rdata_o, 32'h3F800000);
        check_val("s1_outst_before", outstanding_o, 3'd1);
        advance();
        check_cycle();
        check_val("s1_outst_after", outstanding_o, 3'd0);
        advance();

        // Out-of-order completion: A to slow unit1, B to fast unit0.
        issue(2'd1, 2'b10); step();
        issue(2'd0, 2'b01); step();
        idle(); set_res(0, 32'hBBBB0000, 5'h02); step();
        idle();
        check_cycle();
        check_val("s2_b_held", apu_rvalid_o, 1'b0);
        advance();
        set_res(1, 32'hAAAA0000, 5'h01); step();
        idle();
        check_cycle();
        check_val("s2_first_A", apu_rdata_o, 32'hAAAA0000);
        advance();
        check_cycle();
        check_val("s2_second_B", apu_rdata_o, 32'hBBBB0000);
        check_val("s2_flags_B", apu_rflags_o, 5'h02);
        advance();

        // Fill to DEPTH, then a pop in the same cycle must not unblock a push.
        for (int i = 0; i < DEPTH; i++) begin
            issue(2'(i % 2), 2'b11); step();
        end
        issue(2'd0, 2'b11); set_res(0, 32'h12345678, 5'h03);
        check_cycle();
        check_val("full_gnt", apu_gnt_o, 1'b0);
        advance();
        issue(2'd0, 2'b11);
        check_cycle();
        check_val("full_pop_gnt", apu_gnt_o, 1'b0);
        check_val("full_pop_rvalid", apu_rvalid_o, 1'b1);
        advance();
        issue(2'd0, 2'b11);
        check_cycle();
        check_val("after_pop_gnt", apu_gnt_o, 1'b1);
        check_val("after_pop_outst", outstanding_o, 3'd3);
        advance();
        do_reset();

        // Out-of-range unit: granted, zero result, sticky error.
        issue(2'd3, 2'b00);
        check_cycle();
        check_val("oor_gnt", apu_gnt_o, 1'b1);
        advance();
        idle();
        check_cycle();
        check_val("oor_rvalid", apu_rvalid_o, 1'b1);
        check_val("oor_rdata", apu_rdata_o, 32'd0);
        check_val("oor_err", err_o, 1'b1);
        advance();
        repeat (3) step();
        check_cycle();
        check_val("oor_err_sticky", err_o, 1'b1);
        advance();
        do_reset();
        check_cycle();
        check_val("err_cleared", err_o, 1'b0);
        advance();

        // Stray result from unit1 with nothing outstanding.
        set_res(1, 32'hDEAD0000, 5'h1F); step();
        idle();
        check_cycle();
        check_val("stray_rvalid", apu_rvalid_o, 1'b0);
        check_val("stray_err", err_o, 1'b1);
        advance();
        do_reset();

        // Reset with three ops in flight and one result buffered.
        issue(2'd1, 2'b10); step();
        issue(2'd0, 2'b01); step();
        issue(2'd0, 2'b01); step();
        idle(); set_res(0, 32'h55550000, 5'h04); step();
        idle(); rst = 1'b1;
        check_cycle();
        check_val("pre_rst_outst", outstanding_o, 3'd3);
        advance();
        idle(); set_res(1, 32'h77770000, 5'h05);
        check_cycle();
        check_val("post_rst_outst", outstanding_o, 3'd0);
        check_val("post_rst_rvalid", apu_rvalid_o, 1'b0);
        check_val("post_rst_rdata", apu_rdata_o, 32'd0);
        check_val("post_rst_err", err_o, 1'b0);
        advance();
        idle();
        check_cycle();
        check_val("no_stale_rvalid", apu_rvalid_o, 1'b0);
        check_val("late_result_err", err_o, 1'b1);
        advance();
        do_reset();

        // Random legal traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            idle();
            req  = 1'($urandom_range(0, 1));
            unit = 2'($urandom_range(0, NUM_UNITS - 1));
            gnt  = 2'($urandom_range(0, 3));
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (pending(u) > 0 && $urandom_range(0, 2) == 0) set_res(u, $urandom, 5'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
